// File: rtl/bit_packer_writer.sv
// bit_packer_writer: packs variable-length codes LSB-first (DEFLATE bit
// order) into WORD_W-bit words and writes them to an output memory.
// Supports an explicit flush with zero padding, a running count of
// accepted bits, and a sticky overflow flag when DEPTH words are exceeded.
module bit_packer_writer #(
  parameter int WORD_W       = 8,
  parameter int MAX_CODE_LEN = 15,
  parameter int DEPTH        = 16,
  parameter int LEN_W        = 5,
  parameter int ADDR_W       = 4,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    code_valid,
  output logic                    code_ready,
  input  logic [MAX_CODE_LEN-1:0] code_bits,
  input  logic [LEN_W-1:0]        code_len,
  input  logic                    flush,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [WORD_W-1:0]       mem_wdata,
  output logic                    done,
  output logic                    overflow,
  output logic [CNT_W-1:0]        total_bits
);

  localparam int ACC_W  = WORD_W + MAX_CODE_LEN;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int WCNT_W = ADDR_W + 1;

  localparam logic [FILL_W-1:0] WORD_FILL = FILL_W'(WORD_W);
  localparam logic [WCNT_W-1:0] DEPTH_CNT = WCNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ACC_W-1:0]        acc;
  logic [FILL_W-1:0]       fill;
  logic [WCNT_W-1:0]       wcnt;
  logic                    ovf;
  logic [CNT_W-1:0]        tbits;

  logic [MAX_CODE_LEN-1:0] mask;
  logic [ACC_W-1:0]        code_ext;
  logic                    full_word;
  logic                    at_limit;
  logic                    emit;
  logic                    drain;
  logic                    accept;
  logic                    clear;

  // Mask off code bits at or above code_len and align the code at the fill point.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_CODE_LEN; i++) begin
      mask[i] = (i < 32'(code_len));
    end
    code_ext = ACC_W'(code_bits & mask) << fill;
  end

  // Next-state and handshake decode; emitting a word always takes priority over accepting a code.
  always_comb begin
    state_nxt  = state;
    code_ready = 1'b0;
    accept     = 1'b0;
    emit       = 1'b0;
    drain      = 1'b0;
    clear      = 1'b0;
    full_word  = (fill >= WORD_FILL);
    at_limit   = (wcnt == DEPTH_CNT);
    case (state)
      S_IDLE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (full_word) begin
          emit = 1'b1;
          if (at_limit) state_nxt = S_DONE;
        end else if (!ovf) begin
          code_ready = 1'b1;
          accept     = code_valid;
          if (flush) state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (full_word) begin
          emit = 1'b1;
          if (at_limit) state_nxt = S_DONE;
        end else if (fill != '0) begin
          // Bits above fill are already zero, so the padded word is just the low slice.
          emit      = 1'b1;
          drain     = 1'b1;
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Accumulator, counters and registered memory write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      fill      <= '0;
      wcnt      <= '0;
      ovf       <= 1'b0;
      tbits     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (clear) begin
        acc      <= '0;
        fill     <= '0;
        wcnt     <= '0;
        ovf      <= 1'b0;
        tbits    <= '0;
        mem_addr <= '0;
      end else if (emit) begin
        if (at_limit) begin
          ovf <= 1'b1;
        end else begin
          mem_we    <= 1'b1;
          mem_addr  <= wcnt[ADDR_W-1:0];
          mem_wdata <= acc[WORD_W-1:0];
          wcnt      <= wcnt + WCNT_W'(1);
        end
        acc  <= acc >> WORD_W;
        fill <= drain ? '0 : fill - WORD_FILL;
      end else if (accept) begin
        acc   <= acc | code_ext;
        fill  <= fill + FILL_W'(code_len);
        tbits <= tbits + CNT_W'(code_len);
      end
    end
  end

  assign done       = (state == S_DONE);
  assign overflow   = ovf;
  assign total_bits = tbits;

endmodule
